serial_word_receiver: RTL and testbench
=======================================

// Module: serial_word_receiver
// PURPOSE
//  Deserializer for the serial stream produced by the 4-bit shift register's S_OUT in shift mode.
//  - Captures WIDTH consecutive enabled bits and rebuilds the original parallel word in bit order
//    chosen by DIR.
//  - Presents the rebuilt word through a one-entry VALID/READY output buffer.
//  - Sits on the far side of the serial link, feeding the parallel consumer.
// PARAMETERS
//  WIDTH  4  bits per word (>=2); bit counter sized to hold WIDTH
// PORTS
//  CLK      in   1      clock, all state changes on posedge
//  RST      in   1      synchronous, active-high reset
//  ENB      in   1      bit strobe; S_IN sampled only on cycles with ENB=1
//  S_IN     in   1      serial data (driven from the register's S_OUT)
//  DIR      in   1      0: MSB first (left shift), 1: LSB first (right shift); sampled at frame start
//  START    in   1      marks the cycle carrying bit 0 of a frame
//  ABORT    in   1      drops the partial frame in progress
//  READY    in   1      consumer accepts D_OUT this cycle when VALID=1
//  D_OUT    out  WIDTH  received word, stable while VALID=1
//  VALID    out  1      D_OUT holds an unconsumed word
//  BUSY     out  1      frame in progress (state RECV)
//  OVERRUN  out  1      sticky: a completed word was dropped because the buffer was full
// BEHAVIOUR
//  Reset: state=IDLE, count=0, shift reg=0, D_OUT=0, VALID=0, BUSY=0, OVERRUN=0.
//  Reset has priority over every other input.
//  FSM states:
//   - IDLE: on START=1 & ENB=1 & ABORT=0, sample bit 0, latch DIR into dir_q, count<=1, go RECV.
//     START with ENB=0 is ignored.
//   - RECV: on ENB=1, sample S_IN and count<=count+1. START is ignored while in RECV.
//     ABORT=1 returns to IDLE, clears count, discards the partial word; ABORT beats ENB and START.
//   - Completion: the edge that samples bit WIDTH-1 returns to IDLE.
//     A new START can be accepted on the very next cycle; back-to-back frames carry no gap.
//  Assembly:
//   - dir_q=0: sr <= {sr[WIDTH-2:0], S_IN}. First bit lands in MSB.
//   - dir_q=1: sr <= {S_IN, sr[WIDTH-1:1]}. First bit lands in LSB.
//   - Result equals the transmitter's Q before shifting began.
//   - The completed word (including the final bit) is written to D_OUT on the completing edge.
//  Latency: VALID=1 on the cycle after the edge that samples the last bit.
//  Output buffer:
//   - VALID & READY on an edge consumes the word; VALID<=0 unless a new word completes on that edge.
//   - Completion with VALID=0, or with VALID=1 & READY=1: D_OUT<=new word, VALID<=1.
//   - Completion with VALID=1 & READY=0: new word dropped, D_OUT/VALID unchanged, OVERRUN<=1.
//   - D_OUT never changes while VALID=1 & READY=0.
//   - OVERRUN clears only on RST.
//  BUSY = (state==RECV), registered.
//  ENB low mid-frame stalls the frame indefinitely; no timeout.
// TESTING
//  1. RST; START+ENB with DIR=0, S_IN=1,0,1,1 over 4 ENB cycles -> VALID=1 next cycle, D_OUT=4'b1011, BUSY low.
//  2. DIR=1, S_IN=1,1,0,0 (LSB first) -> D_OUT=4'b0011; DIR toggled mid-frame has no effect.
//  3. ENB gaps of 3 cycles between bits, READY=0 -> same word as with no gaps; VALID held, D_OUT stable.
//  4. Word A=4'hA pending with READY=0, word B=4'h5 completes -> D_OUT stays 4'hA, OVERRUN=1.
//     Then READY=1 -> VALID=0; OVERRUN stays 1.
//  5. Back-to-back frames 4'h3, 4'hC with READY=1 on completion edge -> D_OUT=4'h3, then 4'hC; VALID continuous.
//  6. ABORT after 2 bits, then full frame 4'h6 -> D_OUT=4'h6.
//     RST after 3 bits -> all outputs 0, next frame received correctly.

Source files
------------

// File: rtl/serial_word_receiver.sv
// serial_word_receiver
//   Deserializer for the serial stream of a shift register's S_OUT in shift mode.
//   Collects WIDTH enabled bits of a frame, rebuilds the parallel word in the bit
//   order chosen by DIR at frame start, and presents it through a one-entry
//   VALID/READY buffer. A word completing while the buffer holds an unconsumed
//   word is dropped and flagged by the sticky OVERRUN.
// Ports
//   CLK      clock, all state changes on posedge
//   RST      synchronous active-high reset, highest priority
//   ENB      bit strobe; S_IN sampled only when ENB=1
//   S_IN     serial data
//   DIR      0: MSB first, 1: LSB first; sampled with the START bit
//   START    marks the cycle carrying bit 0 of a frame
//   ABORT    drops the partial frame in progress
//   READY    consumer accepts D_OUT on an edge where VALID=1
//   D_OUT    received word, stable while VALID=1 and READY=0
//   VALID    D_OUT holds an unconsumed word
//   BUSY     frame in progress
//   OVERRUN  sticky: a completed word was dropped because the buffer was full
module serial_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENB,
  input  logic             S_IN,
  input  logic             DIR,
  input  logic             START,
  input  logic             ABORT,
  input  logic             READY,
  output logic [WIDTH-1:0] D_OUT,
  output logic             VALID,
  output logic             BUSY,
  output logic             OVERRUN
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sr_q;
  logic             dir_q;

  logic             frame_start;
  logic             bit_take;
  logic             frame_done;
  logic             frame_drop;
  logic             shift_dir;
  logic [WIDTH-1:0] sr_next;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                input logic             b,
                                                input logic             lsb_first);
    if (lsb_first) return {b, sr[WIDTH-1:1]};
    else           return {sr[WIDTH-2:0], b};
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    bit_take    = 1'b0;
    frame_done  = 1'b0;
    frame_drop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START && ENB && !ABORT) begin
          frame_start = 1'b1;
          state_d     = RECV;
        end
      end
      RECV: begin
        // ABORT outranks a simultaneous bit strobe; START is meaningless here.
        if (ABORT) begin
          frame_drop = 1'b1;
          state_d    = IDLE;
        end else if (ENB) begin
          bit_take = 1'b1;
          if (cnt_q == LAST_IDX) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The first bit uses the live DIR because dir_q is only being loaded on that edge.
  assign shift_dir = frame_start ? DIR : dir_q;
  assign sr_next   = shift_in(sr_q, S_IN, shift_dir);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      sr_q    <= '0;
      dir_q   <= 1'b0;
      D_OUT   <= '0;
      VALID   <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      if (frame_start) begin
        dir_q <= DIR;
        sr_q  <= sr_next;
        cnt_q <= CNT_W'(1);
      end else if (frame_drop) begin
        cnt_q <= '0;
      end else if (bit_take) begin
        sr_q  <= sr_next;
        cnt_q <= frame_done ? '0 : cnt_q + CNT_W'(1);
      end

      // sr_next already contains the final bit, so the word is published on the
      // completing edge and VALID rises the cycle after.
      if (frame_done) begin
        if (!VALID || READY) begin
          D_OUT <= sr_next;
          VALID <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end
    end
  end

  assign BUSY = (state_q == RECV);

endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver
//   Scoreboard bench for serial_word_receiver. The driver holds a frame-level
//   reference model (list of received bits, buffer occupancy) and pushes every
//   word the buffer should accept into exp_q; a negedge monitor pops and checks
//   whenever the DUT hands a word over (VALID & READY).
module tb_serial_word_receiver;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST, ENB, S_IN, DIR, START, ABORT, READY;
  logic [W-1:0] D_OUT;
  logic         VALID, BUSY, OVERRUN;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  bit           rx_bits[$];
  bit           m_busy, m_dir, m_valid, m_ovr;
  bit           mon_on = 1'b0;

  serial_word_receiver #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .ENB(ENB), .S_IN(S_IN), .DIR(DIR), .START(START),
    .ABORT(ABORT), .READY(READY), .D_OUT(D_OUT), .VALID(VALID), .BUSY(BUSY),
    .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word rebuilt from the bit list: bit i of the frame is word bit (W-1-i) when
  // MSB first, word bit i when LSB first.
  function automatic logic [W-1:0] assemble(input bit lsb_first);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (lsb_first) w[i] = rx_bits[i];
      else           w[W-1-i] = rx_bits[i];
    end
    return w;
  endfunction

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic step(input bit rst, input bit enb, input bit sin, input bit start,
                      input bit abort, input bit ready, input bit dir);
    bit done;
    logic [W-1:0] word;
    RST = rst; ENB = enb; S_IN = sin; START = start; ABORT = abort; READY = ready; DIR = dir;
    @(posedge CLK);
    #1;
    done = 1'b0;
    word = '0;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_ovr = 0;
      rx_bits.delete();
      exp_q.delete();
    end else begin
      if (!m_busy) begin
        if (start && enb && !abort) begin
          m_busy = 1; m_dir = dir;
          rx_bits.delete();
          rx_bits.push_back(sin);
        end
      end else if (abort) begin
        m_busy = 0;
        rx_bits.delete();
      end else if (enb) begin
        rx_bits.push_back(sin);
        if (rx_bits.size() == W) begin
          word = assemble(m_dir);
          done = 1'b1;
          m_busy = 0;
        end
      end
      if (done) begin
        if (!m_valid || ready) begin
          exp_q.push_back(word);
          m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic send_frame(input logic [W-1:0] word, input bit dir, input int gap,
                            input bit rdy_mid, input bit rdy_last, input bit toggle);
    for (int i = 0; i < W; i++) begin
      bit b, d;
      b = dir ? word[i] : word[W-1-i];
      d = (i == 0) ? dir : (toggle ? ~dir : dir);
      step(0, 1, b, (i == 0), 0, (i == W-1) ? rdy_last : rdy_mid, d);
      if (i != W-1)
        for (int g = 0; g < gap; g++)
          step(0, 0, $urandom_range(1), $urandom_range(1), 0, rdy_mid, $urandom_range(1));
    end
  endtask

  // Monitor: compares flags against the model and pops on each handover.
  always @(negedge CLK) begin
    if (mon_on) begin
      chk("valid", VALID, m_valid);
      chk("busy", BUSY, m_busy);
      chk("overrun", OVERRUN, m_ovr);
      if (VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          chk("d_out", D_OUT, exp_q[0]);
          if (READY === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    m_busy = 0; m_dir = 0; m_valid = 0; m_ovr = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    mon_on = 1'b1;
    chk("reset_dout", D_OUT, 0);
    chk("reset_valid", VALID, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_overrun", OVERRUN, 0);

    // MSB first 1,0,1,1 -> 4'b1011, VALID the cycle after the last bit
    step(0, 1, 1, 1, 0, 0, 0);
    chk("t1_busy", BUSY, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("t1_valid_early", VALID, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("t1_valid", VALID, 1);
    chk("t1_dout", D_OUT, 4'b1011);
    chk("t1_busy_low", BUSY, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t1_consumed", VALID, 0);

    // LSB first 1,1,0,0 -> 4'b0011, DIR toggled mid-frame
    send_frame(4'b0011, 1, 0, 0, 0, 1);
    chk("t2_dout", D_OUT, 4'b0011);
    step(0, 0, 0, 0, 0, 1, 0);

    // gaps of 3 cycles, READY low: word held stable
    send_frame(4'h9, 0, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(1), 0, 0, 0, 0);
    chk("t3_dout", D_OUT, 4'h9);
    step(0, 0, 0, 0, 0, 1, 0);

    // overrun: A pending, B dropped
    send_frame(4'hA, 1, 0, 0, 0, 0);
    send_frame(4'h5, 0, 1, 0, 0, 0);
    chk("t4_dout_held", D_OUT, 4'hA);
    chk("t4_overrun", OVERRUN, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t4_valid_cleared", VALID, 0);
    chk("t4_overrun_sticky", OVERRUN, 1);

    // back-to-back 3 then C, READY only on C's completion edge
    step(1, 0, 0, 0, 0, 0, 0);
    send_frame(4'h3, 0, 0, 0, 0, 0);
    send_frame(4'hC, 1, 0, 0, 1, 0);
    chk("t5_dout_c", D_OUT, 4'hC);
    chk("t5_valid", VALID, 1);
    step(0, 0, 0, 0, 0, 1, 0);

    // ABORT after 2 bits, then 4'h6
    step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0);
    chk("t6_abort_idle", BUSY, 0);
    send_frame(4'h6, 0, 0, 0, 0, 0);
    chk("t6_dout", D_OUT, 4'h6);
    // RST after 3 bits
    step(0, 1, 0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0, 1);
    chk("t6_rst_dout", D_OUT, 0);
    chk("t6_rst_valid", VALID, 0);
    chk("t6_rst_busy", BUSY, 0);
    send_frame(4'hE, 1, 1, 1, 1, 0);
    chk("t6_after_rst", D_OUT, 4'hE);
    step(0, 0, 0, 0, 0, 1, 0);

    // random per-cycle traffic
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(199) == 0), ($urandom_range(3) != 0), $urandom_range(1),
           ($urandom_range(2) == 0), ($urandom_range(15) == 0), $urandom_range(1),
           $urandom_range(1));

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
    chk("queue_drained", exp_q.size(), 0);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
